seven_seg_scan_ctrl: RTL and testbench
======================================

SEVEN_SEG_SCAN_CTRL -- requirements
Module: seven_seg_scan_ctrl

Interface
REQ-001 Parameter REFRESH_DIV, default 100000, clk cycles per digit slot (1 kHz per digit at 100 MHz); legal range 4..2^20.
REQ-002 Parameter BLANK_CYCLES, default 500, anti-ghost cycles with all anodes off at each slot start; legal range 1..REFRESH_DIV-2.
REQ-003 clk  input  1  the single clock, rising edge; synchronous reset is active-low.
REQ-004 rst_n  input  1  synchronous, active-low reset.
REQ-005 bcd_in  input  16  four BCD digits; [3:0] = digit 0 (rightmost), [15:12] = digit 3.
REQ-006 dp_in  input  4  decimal-point enables, one per digit, active-high.
REQ-007 load  input  1  single-cycle strobe; captures bcd_in/dp_in into the shadow register.
REQ-008 lz_en  input  1  leading-zero suppression enable, sampled at frame start.
REQ-009 an  output  4  anode selects, active-low, registered.
REQ-010 seg  output  7  segments {g,f,e,d,c,b,a}, active-low, registered.
REQ-011 dp  output  1  decimal point, active-low, registered.
REQ-012 frame_tick  output  1  one-cycle pulse when the display register is updated.

Function
REQ-013 Prescaler SHALL count 0..REFRESH_DIV-1 and wrap; slot end is the cycle the count equals REFRESH_DIV-1.
REQ-014 Digit index SHALL advance 0->1->2->3->0 at each slot end.
REQ-015 FSM states: BLANK, DRIVE; BLANK->DRIVE when prescaler equals BLANK_CYCLES-1; DRIVE->BLANK at slot end.
REQ-016 In BLANK, an SHALL be 4'b1111, seg 7'b1111111, dp 1.
REQ-017 In DRIVE, exactly one an bit SHALL be 0 (bit = index), unless that digit is suppressed.
REQ-018 Outputs SHALL be registered with one-cycle latency from the FSM state/index that produced them.
REQ-019 seg SHALL be the decode of the selected display nibble: 0-9 standard patterns (0 = 7'b1000000, 8 = 7'b0000000); nibbles 10-15 SHALL give 7'b1111111.
REQ-020 dp SHALL equal the inverse of the selected display dp bit.
REQ-021 load SHALL write the shadow register in the same cycle; the display register SHALL copy the shadow only at the 3->0 wrap.
REQ-022 On load coincident with the 3->0 wrap, the copy SHALL use the pre-load shadow value; the new value SHALL show from the following frame.
REQ-023 frame_tick SHALL pulse in the cycle after the 3->0 copy.
REQ-024 With lz_en latched 1, digit k (k=3..1) SHALL be suppressed (an all 1s in its DRIVE slot) when it and every higher digit equal 0; digit 0 SHALL never be suppressed.
REQ-025 A suppressed digit with its dp bit set SHALL still drive its anode with seg blank and dp 0.

Reset
REQ-026 While rst_n=0 at a clk edge: prescaler 0, index 0, state BLANK, shadow and display registers 0, lz latch 0.
REQ-027 Reset outputs: an=4'b1111, seg=7'b1111111, dp=1, frame_tick=0.
REQ-028 Reset asserted mid-slot SHALL take effect on the next edge; after release, scanning SHALL restart at digit 0 in BLANK.

Structure
REQ-029 Shared package seven_seg_pkg: state enum {BLANK, DRIVE}, NUM_DIGITS=4, SEG_OFF=7'b1111111, AN_OFF=4'b1111.
REQ-030 The segment decode SHALL be one instance of the existing BCDto7Segment decoder; the rest is the scan controller.

Verification (REFRESH_DIV=8, BLANK_CYCLES=2)
REQ-031 Reset release, no load -> an cycles 1110,1101,1011,0111 (2 blank + 6 drive cycles each), seg=7'b1000000 when driven.
REQ-032 load with bcd_in=16'h1234 mid-frame -> old value persists to frame end; after wrap digit 3 shows seg 7'b1111001, frame_tick pulses once.
REQ-033 load with bcd_in=16'h0045, lz_en=1 -> digits 3 and 2 an=1111 in their slots; digits 1,0 show 4 and 5; lz_en=0 -> zeros shown.
REQ-034 load with bcd_in=16'h00A0, dp_in=4'b0100 -> digit 1 seg blank (nibble A), digit 2 dp=0 even with lz_en=1.
REQ-035 load asserted exactly on the 3->0 wrap cycle -> new value first appears one full frame later.
REQ-036 rst_n pulled low during digit 2 DRIVE -> next edge all outputs at reset values; scan resumes at digit 0.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the four-digit seven-segment scan controller.
// Also holds the leading-zero mask helper used by the scan logic.
package seven_seg_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_e;

  localparam int         NUM_DIGITS = 4;
  localparam logic [6:0] SEG_OFF    = 7'b1111111;
  localparam logic [3:0] AN_OFF     = 4'b1111;

  // Bit k set when digit k and every higher digit are zero; digit 0 never masked.
  function automatic logic [NUM_DIGITS-1:0] lz_mask(
    input logic [4*NUM_DIGITS-1:0] bcd,
    input logic                    lz
  );
    logic zero_run;
    lz_mask  = '0;
    zero_run = lz;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      zero_run   = zero_run & (bcd[4*k +: 4] == 4'd0);
      lz_mask[k] = zero_run;
    end
  endfunction

endpackage

// File: rtl/seven_seg_scan_ctrl_decode.sv
// BCD nibble to active-low seven-segment pattern {g,f,e,d,c,b,a}.
// Non-decimal nibbles (10-15) blank the digit.
module BCDto7Segment
  import seven_seg_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    case (bcd)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed driver for a four-digit common-anode display with
// per-slot anti-ghost blanking, frame-synchronous update and leading-zero blanking.
module seven_seg_scan_ctrl
  import seven_seg_pkg::*;
#(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] bcd_in,
  input  logic [3:0]  dp_in,
  input  logic        load,
  input  logic        lz_en,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_tick
);

  localparam int              CNT_W      = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  scan_state_e      state_q, state_d;
  logic [15:0]      shadow_q, shadow_d;
  logic [3:0]       shadow_dp_q, shadow_dp_d;
  logic [15:0]      disp_q, disp_d;
  logic [3:0]       disp_dp_q, disp_dp_d;
  logic             lz_q, lz_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;
  logic             frame_tick_q, frame_tick_d;

  logic             slot_end;
  logic             wrap;
  logic [3:0]       sel_nib;
  logic             sel_dp;
  logic [3:0]       sup_mask;
  logic             sel_sup;
  logic [6:0]       dec_seg;

  // Prescaler and digit index
  always_comb begin
    slot_end = (cnt_q == CNT_LAST);
    wrap     = slot_end && (idx_q == 2'd3);
    cnt_d    = slot_end ? '0 : cnt_q + CNT_W'(1);
    idx_d    = slot_end ? idx_q + 2'd1 : idx_q;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      BLANK:   if (cnt_q == BLANK_LAST) state_d = DRIVE;
      DRIVE:   if (slot_end)            state_d = BLANK;
      default: state_d = BLANK;
    endcase
  end

  // Shadow captures on load; display takes the pre-load shadow at the frame wrap.
  always_comb begin
    shadow_d    = load ? bcd_in : shadow_q;
    shadow_dp_d = load ? dp_in  : shadow_dp_q;
    disp_d      = wrap ? shadow_q    : disp_q;
    disp_dp_d   = wrap ? shadow_dp_q : disp_dp_q;
    lz_d        = wrap ? lz_en       : lz_q;
  end

  always_comb begin
    sel_nib  = disp_q[4*idx_q +: 4];
    sel_dp   = disp_dp_q[idx_q];
    sup_mask = lz_mask(disp_q, lz_q);
    sel_sup  = sup_mask[idx_q];
  end

  BCDto7Segment u_dec (
    .bcd (sel_nib),
    .seg (dec_seg)
  );

  // A suppressed digit with its point lit keeps its anode so the dot shows.
  always_comb begin
    an_d         = AN_OFF;
    seg_d        = SEG_OFF;
    dp_d         = 1'b1;
    frame_tick_d = wrap;
    if (state_q == DRIVE) begin
      if (!sel_sup) begin
        an_d  = ~(4'b0001 << idx_q);
        seg_d = dec_seg;
        dp_d  = ~sel_dp;
      end else if (sel_dp) begin
        an_d  = ~(4'b0001 << idx_q);
        dp_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      idx_q        <= 2'd0;
      state_q      <= BLANK;
      shadow_q     <= '0;
      shadow_dp_q  <= '0;
      disp_q       <= '0;
      disp_dp_q    <= '0;
      lz_q         <= 1'b0;
      an_q         <= AN_OFF;
      seg_q        <= SEG_OFF;
      dp_q         <= 1'b1;
      frame_tick_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      state_q      <= state_d;
      shadow_q     <= shadow_d;
      shadow_dp_q  <= shadow_dp_d;
      disp_q       <= disp_d;
      disp_dp_q    <= disp_dp_d;
      lz_q         <= lz_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Scoreboard bench for seven_seg_scan_ctrl: a cycle-count reference model pushes
// expected outputs at each rising edge; they are compared on the falling edge.
module tb_seven_seg_scan_ctrl;

  localparam int DIV   = 8;
  localparam int BL    = 2;
  localparam int FRAME = 4 * DIV;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       ft;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [15:0] bcd_in;
  logic [3:0]  dp_in;
  logic        load;
  logic        lz_en;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_tick;

  int   total = 0;
  int   bad   = 0;
  exp_t sb_q[$];

  // Model state: m_t counts active edges since reset release.
  int          m_t      = 0;
  logic [15:0] m_shadow = '0;
  logic [3:0]  m_sdp    = '0;
  logic [15:0] m_disp   = '0;
  logic [3:0]  m_ddp    = '0;
  logic        m_lz     = 1'b0;

  seven_seg_scan_ctrl #(
    .REFRESH_DIV  (DIV),
    .BLANK_CYCLES (BL)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bcd_in     (bcd_in),
    .dp_in      (dp_in),
    .load       (load),
    .lz_en      (lz_en),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_tick (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [6:0] ref_seg(input logic [3:0] n);
    case (n)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic model_step();
    exp_t e;
    int   cnt;
    int   idx;
    logic all_zero;
    logic sup;
    e = {4'b1111, 7'b1111111, 1'b1, 1'b0};
    if (!rst_n) begin
      m_t = 0; m_shadow = '0; m_sdp = '0; m_disp = '0; m_ddp = '0; m_lz = 1'b0;
    end else begin
      cnt = m_t % DIV;
      idx = (m_t / DIV) % 4;
      if (cnt >= BL) begin
        all_zero = 1'b1;
        for (int j = idx; j < 4; j++) all_zero = all_zero & (m_disp[4*j +: 4] == 4'd0);
        sup = m_lz && (idx != 0) && all_zero;
        if (!sup) begin
          e.an  = 4'b1111;
          e.an[idx] = 1'b0;
          e.seg = ref_seg(m_disp[4*idx +: 4]);
          e.dp  = ~m_ddp[idx];
        end else if (m_ddp[idx]) begin
          e.an  = 4'b1111;
          e.an[idx] = 1'b0;
          e.dp  = 1'b0;
        end
      end
      e.ft = (cnt == DIV - 1) && (idx == 3);
      if (e.ft) begin
        m_disp = m_shadow;
        m_ddp  = m_sdp;
        m_lz   = lz_en;
      end
      if (load) begin
        m_shadow = bcd_in;
        m_sdp    = dp_in;
      end
      m_t++;
    end
    sb_q.push_back(e);
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    exp_t e;
    @(negedge clk);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("an",         32'(an),         32'(e.an));
      chk("seg",        32'(seg),        32'(e.seg));
      chk("dp",         32'(dp),         32'(e.dp));
      chk("frame_tick", 32'(frame_tick), 32'(e.ft));
    end
  end

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [15:0] b, input logic [3:0] d);
    bcd_in = b;
    dp_in  = d;
    load   = 1'b1;
    @(negedge clk);
    load   = 1'b0;
  endtask

  // Park on the falling edge before the active edge with frame phase ph.
  task automatic wait_phase(input int ph);
    bit found = 1'b0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      if ((m_t % FRAME) == ph) found = 1'b1;
      else @(negedge clk);
    end
    if (!found) chk("wait_phase_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int ft_cnt;
    rst_n = 1'b0; bcd_in = '0; dp_in = '0; load = 1'b0; lz_en = 1'b0;
    run(3);
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_dp", 32'(dp), 32'd1);
    chk("rst_ft", 32'(frame_tick), 32'd0);
    rst_n = 1'b1;
    run(FRAME + 8);

    // Mid-frame load: old value until wrap, then new digits.
    wait_phase(5);
    do_load(16'h1234, 4'b0000);
    wait_phase(28);
    chk("d3_old_seg", 32'(seg), 32'h40);
    run(1);
    wait_phase(28);
    chk("d3_new_seg", 32'(seg), 32'h79);
    chk("d3_new_an", 32'(an), 32'h7);
    ft_cnt = 0;
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      if (frame_tick) ft_cnt++;
    end
    chk("ft_per_frame", 32'(ft_cnt), 32'd1);

    // Leading-zero suppression on and off.
    lz_en = 1'b1;
    do_load(16'h0045, 4'b0000);
    run(3 * FRAME);
    lz_en = 1'b0;
    run(2 * FRAME);

    // Non-decimal nibble and dot on a suppressed digit.
    lz_en = 1'b1;
    do_load(16'h00A0, 4'b0100);
    run(3 * FRAME);
    wait_phase(20);
    chk("d2_dot_dp", 32'(dp), 32'd0);
    chk("d2_dot_an", 32'(an), 32'hB);

    // Load exactly on the wrap edge.
    lz_en = 1'b0;
    wait_phase(FRAME - 1);
    do_load(16'h9876, 4'b1001);
    run(3 * FRAME);

    // Reset during digit 2 drive.
    wait_phase(2 * DIV + 4);
    rst_n = 1'b0;
    run(1);
    chk("midrst_an", 32'(an), 32'hF);
    chk("midrst_seg", 32'(seg), 32'h7F);
    rst_n = 1'b1;
    run(FRAME + 4);

    // Random loads at random times.
    for (int k = 0; k < 12; k++) begin
      lz_en = 1'($urandom_range(0, 1));
      do_load(16'($urandom), 4'($urandom));
      run($urandom_range(1, 2 * FRAME));
    end
    run(2 * FRAME);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
